// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: two-entry (main + skid) registered pipeline stage with flush,
// kill-masked control outputs and a saturating downstream-stall counter.
module pipeline_stage_skid #(
    parameter int                 DATA_W    = 32,
    parameter int                 RD_W      = 5,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  KILL_MASK = '1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PAY_W = 2 * DATA_W + RD_W + CTRL_W;

    logic [PAY_W-1:0] main_q, main_d, skid_q, skid_d, in_pay;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, release_w, stall;
    logic [CTRL_W-1:0] ctrl_q;

    assign in_pay    = {in_data0, in_data1, in_rd, in_ctrl};
    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign release_w = main_valid_q & out_ready;
    assign stall     = main_valid_q & ~out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || release_w) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                main_d       = accept ? in_pay : main_q;
            end
        end else if (accept) begin
            // downstream stalled: park the new slot so upstream sees backpressure next cycle
            skid_valid_d = 1'b1;
            skid_d       = in_pay;
        end
        cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign {out_data0, out_data1, out_rd, ctrl_q} = main_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_valid_q ? ctrl_q : (ctrl_q & ~KILL_MASK);
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb_pipeline_stage_skid: directed and scoreboarded checks of the skid pipeline stage,
// with a CNT_W=3 twin sharing the inputs for counter saturation.
module tb_pipeline_stage_skid;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data0 = '0, in_data1 = '0;
    logic [4:0]  in_rd = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [31:0] out_data0, out_data1, s_out_data0, s_out_data1;
    logic [4:0]  out_rd, s_out_rd;
    logic [7:0]  out_ctrl, s_out_ctrl;
    logic [15:0] stall_cnt;
    logic [2:0]  s_stall_cnt;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    pipeline_stage_skid dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipeline_stage_skid #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data0(s_out_data0), .out_data1(s_out_data1), .out_rd(s_out_rd), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d0, input logic [7:0] c, input logic r);
        in_valid = v;
        in_data0 = d0;
        in_data1 = ~d0;
        in_rd    = d0[4:0];
        in_ctrl  = c;
        out_ready = r;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_w;
    logic        rdy_before;
    int          sent, got_n;

    initial begin
        tick; tick;
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data0", out_data0, 0);
        check("rst_data1", out_data1, 0);
        check("rst_rd", out_rd, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_cnt", stall_cnt, 0);

        drive(1, 32'hDEADBEEF, 8'h0F, 1);
        in_rd = 5;
        tick;
        check("lat1_valid", out_valid, 1);
        check("lat1_data0", out_data0, 32'hDEADBEEF);
        check("lat1_rd", out_rd, 5);
        check("lat1_ctrl", out_ctrl, 8'h0F);
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 8'h30, 1);
            tick;
            check("stream_data", out_data0, i);
            check("stream_ready", in_ready, 1);
        end
        drive(0, 32'h0, 8'h0, 1);
        tick;
        check("empty_valid", out_valid, 0);
        check("empty_ctrl_kill", out_ctrl, 0);
        check("empty_data_hold", out_data0, 4);

        drive(1, 32'hA, 8'h11, 0);
        tick;
        check("stallA_out", out_data0, 32'hA);
        drive(1, 32'hB, 8'h22, 0);
        tick;
        check("stallB_ready", in_ready, 0);
        check("stallB_main", out_data0, 32'hA);
        drive(1, 32'hC, 8'h33, 0);
        tick;
        check("stallC_main", out_data0, 32'hA);
        check("stallC_ready", in_ready, 0);
        drive(1, 32'hC, 8'h33, 1);
        tick;
        check("order_B", out_data0, 32'hB);
        check("order_B_ctrl", out_ctrl, 8'h22);
        check("order_B_ready", in_ready, 1);
        tick;
        check("order_C", out_data0, 32'hC);
        drive(0, 32'h0, 8'h0, 1);
        tick;
        check("order_done", out_valid, 0);
        check("stall_cnt2", stall_cnt, 2);

        drive(1, 32'h100, 8'hA5, 0);
        tick;
        drive(1, 32'h200, 8'h5A, 0);
        tick;
        check("full_ready", in_ready, 0);
        drive(1, 32'h300, 8'hFF, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        check("flush_ready", in_ready, 1);
        drive(0, 32'h0, 8'h0, 1);
        tick;
        check("flush_gone", out_valid, 0);
        tick;
        check("flush_gone2", out_valid, 0);
        check("flush_keeps_cnt", stall_cnt, 4);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("cnt_rst_s", s_stall_cnt, 0);
        drive(1, 32'h77, 8'h01, 0);
        tick;
        drive(0, 32'h0, 8'h0, 0);
        repeat (10) tick;
        check("sat_small", s_stall_cnt, 7);
        check("sat_big", stall_cnt, 10);
        drive(1, 32'h88, 8'h02, 0);
        tick;
        check("sat_hold", s_stall_cnt, 7);
        check("sat_big11", stall_cnt, 11);
        check("both_full", in_ready, 0);
        drive(1, 32'h99, 8'h03, 1);
        flush = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        flush = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_data0", out_data0, 0);
        check("midrst_ctrl", out_ctrl, 0);
        check("midrst_cnt", stall_cnt, 0);
        check("midrst_cnt_s", s_stall_cnt, 0);

        sent = 0;
        got_n = 0;
        for (int cyc = 0; cyc < 2000 && got_n < 100; cyc++) begin
            drive(sent < 100 && $urandom_range(0, 3) != 0, 32'h1000 + sent, 8'($urandom), cyc >= 1500 || $urandom_range(0, 1) == 1);
            in_data1 = $urandom;
            rdy_before = in_ready;
            out_ready = ~out_ready;
            #1;
            if (in_ready !== rdy_before) check("ready_comb", in_ready, rdy_before);
            out_ready = ~out_ready;
            #1;
            if (out_valid && out_ready) begin
                exp_w = q.size() > 0 ? q.pop_front() : 64'hX;
                check("rand_order", {out_data0, out_data1}, exp_w);
                got_n++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_data0, in_data1});
                sent++;
            end
            tick;
        end
        check("rand_count", got_n, 100);
        check("rand_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
